// File: rtl/aes_enc_loader.sv
// aes_enc_loader: collects 32-bit host words into the cipher key and the
// plaintext block and hands them to aes_enc with one-cycle dv pulses,
// sequenced against the busy_exp / busy_enc handshakes.
module aes_enc_loader #(
  parameter int GUARD_CYC = 2
) (
  input  logic         mclk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic         wr_sel,
  input  logic [31:0]  wr_data,
  input  logic [1:0]   key_len,
  output logic         wr_ready,
  output logic         wr_err,
  output logic         key_loaded,
  output logic         keylength128,
  output logic         keylength192,
  output logic         keylength256,
  output logic [0:255] cipherkey,
  output logic         cipherkey_dv,
  output logic [0:127] plaintext,
  output logic         plaintext_dv,
  input  logic         busy_exp,
  input  logic         busy_enc
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KEY_DV   = 3'd1,
    KEY_WAIT = 3'd2,
    PT_DV    = 3'd3,
    PT_WAIT  = 3'd4
  } state_t;

  localparam logic [2:0] GUARD_INIT = 3'(GUARD_CYC);

  // Number of 32-bit words making up a key of the given length code.
  function automatic logic [3:0] key_words(input logic [1:0] kl);
    logic [3:0] n;
    case (kl)
      2'b00:   n = 4'd4;
      2'b01:   n = 4'd6;
      2'b10:   n = 4'd8;
      default: n = 4'd4;
    endcase
    return n;
  endfunction

  state_t       state_r;
  state_t       state_s;
  logic [3:0]   key_cnt_r;
  logic [2:0]   pt_cnt_r;
  logic [1:0]   klen_r;
  logic [2:0]   guard_r;
  logic [255:0] cipherkey_r;
  logic [127:0] plaintext_r;
  logic         key_loaded_r;
  logic         wr_err_r;
  logic         ck_dv_r;
  logic         pt_dv_r;
  logic [2:0]   klen_oh_r;

  logic [3:0]   key_n_s;
  logic         idle_s;
  logic         key_full_s;
  logic         pt_full_s;
  logic         wr_ready_s;
  logic         wr_fire_s;
  logic         key_wr_s;
  logic         pt_wr_s;
  logic         rej_s;
  logic         key_done_s;
  logic         pt_done_s;

  // Write acceptance, rejection and buffer-complete lookahead.
  always_comb begin
    key_n_s    = key_words(klen_r);
    idle_s     = (state_r == IDLE);
    key_full_s = (key_cnt_r == key_n_s);
    pt_full_s  = (pt_cnt_r == 3'd4);
    wr_ready_s = idle_s && (wr_sel ? !pt_full_s : !key_full_s);
    wr_fire_s  = wr_en && wr_ready_s;
    key_wr_s   = wr_fire_s && !wr_sel && !((key_cnt_r == 4'd0) && (key_len == 2'b11));
    pt_wr_s    = wr_fire_s && wr_sel && key_loaded_r;
    rej_s      = wr_fire_s && !key_wr_s && !pt_wr_s;
    // A buffer counts as complete in the very cycle its last word is written,
    // so the dv pulse follows the final accepted word by one cycle.
    key_done_s = key_full_s || (key_wr_s && ((key_cnt_r + 4'd1) == key_n_s));
    pt_done_s  = pt_full_s || (pt_wr_s && (pt_cnt_r == 3'd3));
  end

  // Next-state selection; a complete key always takes priority over plaintext.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (key_done_s && !busy_exp) begin
          state_s = KEY_DV;
        end else if (pt_done_s && key_loaded_r && !busy_enc) begin
          state_s = PT_DV;
        end else begin
          state_s = IDLE;
        end
      end
      KEY_DV: state_s = KEY_WAIT;
      KEY_WAIT: begin
        if ((guard_r == 3'd0) && !busy_exp) begin
          state_s = IDLE;
        end else begin
          state_s = KEY_WAIT;
        end
      end
      PT_DV: state_s = PT_WAIT;
      PT_WAIT: begin
        if ((guard_r == 3'd0) && !busy_enc) begin
          state_s = IDLE;
        end else begin
          state_s = PT_WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and busy-ignore guard counter (armed during each dv cycle).
  always_ff @(posedge mclk) begin
    if (rst) begin
      state_r <= IDLE;
      guard_r <= 3'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == KEY_DV) || (state_r == PT_DV)) begin
        guard_r <= GUARD_INIT;
      end else if (guard_r != 3'd0) begin
        guard_r <= guard_r - 3'd1;
      end
    end
  end

  // Word counters and data buffers; word i lands at bits [32i +: 32] from the MSB.
  always_ff @(posedge mclk) begin
    if (rst) begin
      key_cnt_r   <= 4'd0;
      pt_cnt_r    <= 3'd0;
      klen_r      <= 2'b00;
      cipherkey_r <= 256'd0;
      plaintext_r <= 128'd0;
    end else begin
      if (state_r == KEY_DV) begin
        key_cnt_r <= 4'd0;
      end else if (key_wr_s) begin
        key_cnt_r <= key_cnt_r + 4'd1;
        if (key_cnt_r == 4'd0) begin
          klen_r      <= key_len;
          cipherkey_r <= {wr_data, 224'd0};
        end else begin
          // {~i, 5'b11111} == 255 - 32*i: top bit of word slot i.
          cipherkey_r[{~key_cnt_r[2:0], 5'b11111} -: 32] <= wr_data;
        end
      end
      if (state_r == PT_DV) begin
        pt_cnt_r <= 3'd0;
      end else if (pt_wr_s) begin
        pt_cnt_r <= pt_cnt_r + 3'd1;
        plaintext_r[{~pt_cnt_r[1:0], 5'b11111} -: 32] <= wr_data;
      end
    end
  end

  // Registered handshake outputs: dv pulses, error pulse, key status and length.
  always_ff @(posedge mclk) begin
    if (rst) begin
      ck_dv_r      <= 1'b0;
      pt_dv_r      <= 1'b0;
      wr_err_r     <= 1'b0;
      key_loaded_r <= 1'b0;
      klen_oh_r    <= 3'b000;
    end else begin
      ck_dv_r  <= (state_s == KEY_DV);
      pt_dv_r  <= (state_s == PT_DV);
      wr_err_r <= rej_s;
      if (state_s == KEY_DV) begin
        key_loaded_r <= 1'b0;
        klen_oh_r    <= {klen_r == 2'b00, klen_r == 2'b01, klen_r == 2'b10};
      end else if ((state_r == KEY_WAIT) && (state_s == IDLE)) begin
        key_loaded_r <= 1'b1;
      end
    end
  end

  assign wr_ready     = wr_ready_s;
  assign wr_err       = wr_err_r;
  assign key_loaded   = key_loaded_r;
  assign keylength128 = klen_oh_r[2];
  assign keylength192 = klen_oh_r[1];
  assign keylength256 = klen_oh_r[0];
  assign cipherkey    = cipherkey_r;
  assign cipherkey_dv = ck_dv_r;
  assign plaintext    = plaintext_r;
  assign plaintext_dv = pt_dv_r;

endmodule

// File: tb/tb_aes_enc_loader.sv
// Bench for aes_enc_loader: directed key/plaintext vectors from a table,
// hand-written corner sequences, and a randomized phase checked by a
// transaction-level scoreboard of expected keys and plaintext blocks.
module tb_aes_enc_loader;
  localparam int G = 2;

  logic         mclk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic         wr_sel;
  logic [31:0]  wr_data;
  logic [1:0]   key_len;
  logic         wr_ready;
  logic         wr_err;
  logic         key_loaded;
  logic         keylength128;
  logic         keylength192;
  logic         keylength256;
  logic [255:0] cipherkey;
  logic         cipherkey_dv;
  logic [127:0] plaintext;
  logic         plaintext_dv;
  logic         busy_exp;
  logic         busy_enc;

  aes_enc_loader #(.GUARD_CYC(G)) dut (
    .mclk(mclk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .key_len(key_len), .wr_ready(wr_ready), .wr_err(wr_err), .key_loaded(key_loaded),
    .keylength128(keylength128), .keylength192(keylength192), .keylength256(keylength256),
    .cipherkey(cipherkey), .cipherkey_dv(cipherkey_dv), .plaintext(plaintext),
    .plaintext_dv(plaintext_dv), .busy_exp(busy_exp), .busy_enc(busy_enc)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic [2:0]   kl;
    logic [255:0] key;
  } kexp_t;

  typedef struct packed {
    logic [1:0]   klen;
    logic [1:0]   flip;
    logic [3:0]   n;
    logic [4:0]   busy;
    logic [255:0] key;
  } kvec_t;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int exp_len = 10, enc_len = 12, exp_left = 0, enc_left = 0;
  bit enc_hold = 1'b0;
  bit enc_b = 1'b0;
  int ck_cnt = 0, pt_cnt = 0, ck_cyc = -100, pt_cyc = -100;
  bit ck_prev = 1'b0, pt_prev = 1'b0;
  kexp_t        kq[$];
  logic [127:0] pq[$];
  kvec_t        tbl[3];

  function automatic logic [2:0] onehot(input logic [1:0] k);
    case (k)
      2'b00:   return 3'b100;
      2'b01:   return 3'b010;
      2'b10:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One clock: advance, check any dv pulse against the scoreboard, update busy model.
  task automatic cyc();
    kexp_t        e;
    logic [127:0] p;
    @(posedge mclk);
    #1;
    cyc_n++;
    if (cipherkey_dv) begin
      ck_cnt++;
      ck_cyc = cyc_n;
      chk("ck_dv_width", ck_prev, 0);
      chk("key_loaded_low_in_dv", key_loaded, 0);
      if (kq.size() == 0) begin
        chk("ck_dv_expected", 0, 1);
      end else begin
        e = kq.pop_front();
        chk("cipherkey", cipherkey, e.key);
        chk("keylength", {keylength128, keylength192, keylength256}, e.kl);
      end
    end
    if (plaintext_dv) begin
      pt_cnt++;
      pt_cyc = cyc_n;
      chk("pt_dv_width", pt_prev, 0);
      chk("pt_key_loaded", key_loaded, 1);
      if (ck_cnt > 0) chk("pt_after_ck_gap", (cyc_n - ck_cyc) >= (G + 1), 1);
      if (pq.size() == 0) begin
        chk("pt_dv_expected", 0, 1);
      end else begin
        p = pq.pop_front();
        chk("plaintext", plaintext, p);
      end
    end
    ck_prev = cipherkey_dv;
    pt_prev = plaintext_dv;
    if (rst) begin
      exp_left = 0; enc_left = 0; busy_exp = 1'b0; enc_b = 1'b0;
    end else begin
      if (cipherkey_dv) begin exp_left = exp_len; busy_exp = 1'b0; end
      else if (exp_left > 0) begin busy_exp = 1'b1; exp_left--; end
      else busy_exp = 1'b0;
      if (plaintext_dv) begin enc_left = enc_len; enc_b = 1'b0; end
      else if (enc_left > 0) begin enc_b = 1'b1; enc_left--; end
      else enc_b = 1'b0;
    end
    busy_enc = enc_b | enc_hold;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  // Present one word, wait (bounded) for wr_ready, complete the handshake.
  task automatic wr(input bit sel, input logic [31:0] d, input logic [1:0] kl, output int acc);
    int t;
    wr_en = 1'b1; wr_sel = sel; wr_data = d; key_len = kl;
    #1;
    t = 0;
    while (!wr_ready && t < 300) begin cyc(); #1; t++; end
    if (!wr_ready) chk("wr_ready_timeout", 0, 1);
    cyc();
    acc = cyc_n;
    wr_en = 1'b0;
  endtask

  task automatic load_key(input logic [1:0] kl, input int n, input logic [255:0] key,
                          input logic [1:0] flip, output int last_acc);
    int a;
    for (int i = 0; i < n; i++) begin
      wr(1'b0, key[255 - 32*i -: 32], (i == 1) ? flip : kl, a);
    end
    last_acc = a;
  endtask

  task automatic wait_loaded(output int c);
    int t;
    t = 0;
    while (!key_loaded && t < 100) begin cyc(); t++; end
    if (!key_loaded) chk("key_loaded_timeout", 0, 1);
    c = cyc_n;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ctl"}, {wr_ready, wr_err, key_loaded, keylength128, keylength192,
                       keylength256, cipherkey_dv, plaintext_dv}, 8'h80);
    chk({nm, "_key"}, cipherkey, 0);
    chk({nm, "_pt"}, plaintext, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int a, lc, n0, t, kn;
    logic [1:0]   kl;
    logic [255:0] k;
    logic [127:0] p;

    tbl[0] = '{klen: 2'b00, flip: 2'b00, n: 4'd4, busy: 5'd10,
               key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0}};
    tbl[1] = '{klen: 2'b01, flip: 2'b10, n: 4'd6, busy: 5'd7,
               key: {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}};
    tbl[2] = '{klen: 2'b10, flip: 2'b00, n: 4'd8, busy: 5'd3,
               key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4};

    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_data = 32'd0; key_len = 2'b00;
    busy_exp = 1'b0; busy_enc = 1'b0;
    idle(2);
    rst = 1'b0;
    chk_reset("reset");

    // Rejections: plaintext before any key, illegal key length on first word.
    wr(1'b1, 32'hdeadbeef, 2'b00, a);
    chk("rej_pt_err", wr_err, 1);
    cyc();
    chk("rej_pt_err_pulse", wr_err, 0);
    wr(1'b0, 32'h12345678, 2'b11, a);
    chk("rej_klen_err", wr_err, 1);
    cyc();
    chk("rej_klen_err_pulse", wr_err, 0);
    idle(3);
    chk("rej_no_dv", ck_cnt + pt_cnt, 0);

    // Table of key loads: 128, 192 with a length flip, 256.
    for (int v = 0; v < 3; v++) begin
      exp_len = int'(tbl[v].busy);
      kq.push_back('{kl: onehot(tbl[v].klen), key: tbl[v].key});
      n0 = ck_cnt;
      for (int i = 0; i < int'(tbl[v].n) - 1; i++) begin
        wr(1'b0, tbl[v].key[255 - 32*i -: 32], (i == 1) ? tbl[v].flip : tbl[v].klen, a);
      end
      chk("kv_no_early_dv", ck_cnt, n0);
      wr(1'b0, tbl[v].key[255 - 32*(int'(tbl[v].n) - 1) -: 32], tbl[v].klen, a);
      chk("kv_dv_latency", ck_cyc, a);
      chk("kv_dv_count", ck_cnt, n0 + 1);
      wait_loaded(lc);
      chk("kv_loaded_cycle", lc, ck_cyc + imax(exp_len, G) + 2);
      chk("kv_keylength_hold", {keylength128, keylength192, keylength256}, onehot(tbl[v].klen));
    end

    // Plaintext issue with busy_enc held 12 cycles; write during busy is dropped.
    enc_len = 12;
    p = 128'h00112233445566778899aabbccddeeff;
    pq.push_back(p);
    n0 = pt_cnt;
    for (int i = 0; i < 4; i++) wr(1'b1, p[127 - 32*i -: 32], 2'b00, a);
    chk("pt_dv_count", pt_cnt, n0 + 1);
    wr_en = 1'b1; wr_sel = 1'b1; wr_data = 32'hffffffff;
    #1;
    chk("drop_ready_low", wr_ready, 0);
    cyc();
    chk("drop_no_err", wr_err, 0);
    wr_en = 1'b0;
    #1;
    t = 0;
    while (!wr_ready && t < 100) begin cyc(); #1; t++; end
    chk("pt_ready_return", cyc_n, pt_cyc + imax(enc_len, G) + 2);

    // Simultaneous completion: plaintext pending behind busy_enc, then a new key.
    enc_hold = 1'b1; busy_enc = 1'b1;
    p = 128'h3243f6a8885a308d313198a2e0370734;
    pq.push_back(p);
    n0 = pt_cnt;
    for (int i = 0; i < 4; i++) wr(1'b1, p[127 - 32*i -: 32], 2'b00, a);
    idle(3);
    chk("sim_pt_held", pt_cnt, n0);
    exp_len = 5;
    k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    kq.push_back('{kl: 3'b100, key: k});
    load_key(2'b00, 4, k, 2'b00, a);
    chk("sim_ck_latency", ck_cyc, a);
    enc_hold = 1'b0;
    t = 0;
    while (pt_cnt == n0 && t < 100) begin cyc(); t++; end
    chk("sim_pt_issued", pt_cnt, n0 + 1);
    chk("sim_pt_after_key", pt_cyc >= ck_cyc + G + 1, 1);

    // Reset in KEY_WAIT.
    exp_len = 10;
    k = {128'hffeeddccbbaa99887766554433221100, 128'h0};
    kq.push_back('{kl: 3'b100, key: k});
    load_key(2'b00, 4, k, 2'b00, a);
    n0 = ck_cnt + pt_cnt;
    idle(3);
    do_reset();
    chk_reset("rst_keywait");
    idle(15);
    chk("rst_keywait_no_dv", ck_cnt + pt_cnt, n0);
    chk("rst_keywait_unloaded", key_loaded, 0);

    // Reset after three key words, then a normal 4-word load.
    for (int i = 0; i < 3; i++) wr(1'b0, 32'ha5a5a5a5 + i, 2'b00, a);
    do_reset();
    chk_reset("rst_partial");
    idle(5);
    chk("rst_partial_no_dv", ck_cnt + pt_cnt, n0);
    k = {128'h0f0e0d0c0b0a09080706050403020100, 128'h0};
    kq.push_back('{kl: 3'b100, key: k});
    load_key(2'b00, 4, k, 2'b00, a);
    chk("rst_reload_latency", ck_cyc, a);
    wait_loaded(lc);
    chk("rst_reload_loaded", lc, ck_cyc + imax(exp_len, G) + 2);

    // Randomized keys, plaintext blocks and busy lengths against the scoreboard.
    for (int r = 0; r < 8; r++) begin
      kl = 2'($urandom_range(0, 2));
      kn = (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
      k = 256'd0;
      for (int i = 0; i < kn; i++) k[255 - 32*i -: 32] = $urandom;
      exp_len = $urandom_range(0, 12);
      enc_len = $urandom_range(0, 12);
      kq.push_back('{kl: onehot(kl), key: k});
      load_key(kl, kn, k, 2'($urandom), a);
      for (int b = 0; b < int'($urandom_range(1, 2)); b++) begin
        p = {$urandom, $urandom, $urandom, $urandom};
        pq.push_back(p);
        for (int i = 0; i < 4; i++) wr(1'b1, p[127 - 32*i -: 32], 2'($urandom), a);
      end
    end
    t = 0;
    while ((kq.size() != 0 || pq.size() != 0) && t < 300) begin cyc(); t++; end
    chk("rand_keys_drained", kq.size(), 0);
    chk("rand_pts_drained", pq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_enc_loader.md
Name: aes_enc_loader

Overview:
- Upstream front-end for `aes_enc`. Accepts 32-bit word writes from a host bus and assembles them into the 128/192/256-bit cipher key and the 128-bit plaintext block.
- Drives the `aes_enc` key and plaintext inputs with single-cycle data-valid pulses, sequenced against `busy_exp` and `busy_enc`.
- Never issues a plaintext block before the current key has finished expanding.

Parameters:
- GUARD_CYC, 2: cycles after each dv pulse during which the busy input is ignored. This covers the `aes_enc` busy-rise latency. Legal range is 1 to 7.

Ports:
- mclk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  host write strobe
- wr_sel  in  1  write target: 0 = key word, 1 = plaintext word
- wr_data  in  32  write data word
- key_len  in  2  key length, sampled on the first key word only: 00 = 128, 01 = 192, 10 = 256, 11 = illegal
- wr_ready  out  1  write accepted this cycle when wr_en && wr_ready
- wr_err  out  1  one-cycle pulse when a write is rejected
- key_loaded  out  1  expanded key is available in `aes_enc`
- keylength128  out  1  to aes_enc
- keylength192  out  1  to aes_enc
- keylength256  out  1  to aes_enc
- cipherkey  out  [0:255]  to aes_enc
- cipherkey_dv  out  1  to aes_enc
- plaintext  out  [0:127]  to aes_enc
- plaintext_dv  out  1  to aes_enc
- busy_exp  in  1  from aes_enc
- busy_enc  in  1  from aes_enc

Behaviour:
- Reset values (rst high at an mclk edge), all outputs 0 except as noted:
  - wr_ready = 1; wr_err, key_loaded, keylength*, cipherkey, cipherkey_dv, plaintext, plaintext_dv = 0.
  - key_cnt = 0, pt_cnt = 0, FSM = IDLE.
  - Reset asserted mid-operation aborts everything in the same way; no dv pulse is emitted after reset.
- FSM states: IDLE, KEY_DV, KEY_WAIT, PT_DV, PT_WAIT.
- wr_ready is 1 only in IDLE, and only while the selected buffer is not complete.
- Key writes:
  - First word (key_cnt = 0):
    - Latch key_len into klen.
    - Clear cipherkey to zero and write the word to cipherkey[0:31].
    - If key_len = 11, reject the word and pulse wr_err.
  - Word i goes to cipherkey[32i : 32i+31].
  - Key is complete when key_cnt reaches N, where N = 4, 6 or 8 for klen 00, 01, 10.
  - key_len changes after the first word are ignored.
- Plaintext writes:
  - Word i goes to plaintext[32i : 32i+31]; the block is complete at pt_cnt = 4.
  - A plaintext write while key_loaded = 0 is rejected, pulses wr_err, and pt_cnt is unchanged.
- A write with wr_en high while wr_ready is low is dropped silently (no wr_err).
- IDLE:
  - Key complete and busy_exp = 0 → KEY_DV.
  - Otherwise, plaintext complete, key_loaded = 1 and busy_enc = 0 → PT_DV.
  - If both are complete in the same cycle, the key wins. The pending plaintext is then encrypted with the new key after it loads.
- KEY_DV (1 cycle):
  - cipherkey_dv = 1.
  - keylength128/192/256 are registered one-hot from klen; they are updated on this cycle and held until the next KEY_DV.
  - key_loaded = 0; key_cnt = 0.
  - Next state: KEY_WAIT.
- KEY_WAIT:
  - Ignore busy_exp for GUARD_CYC cycles, then wait for busy_exp = 0.
  - On exit: key_loaded = 1, → IDLE.
- PT_DV (1 cycle): plaintext_dv = 1; pt_cnt = 0; → PT_WAIT.
- PT_WAIT: ignore busy_enc for GUARD_CYC cycles, then wait for busy_enc = 0, → IDLE.
- Data hold:
  - cipherkey and plaintext stay stable from the dv cycle until the next accepted write to the same buffer.
  - No buffer is writable outside IDLE, so data is held during expansion and encryption.
- Minimum latency:
  - Last key word accepted at cycle t → cipherkey_dv at t+1.
  - plaintext_dv never occurs earlier than GUARD_CYC+1 cycles after a cipherkey_dv.

Test Plan:
- Key load, 128-bit:
  - Stimulus: key_len = 00; key words 00010203, 04050607, 08090a0b, 0c0d0e0f; busy_exp model high for 10 cycles after dv.
  - Required: cipherkey_dv is exactly 1 cycle, 1 cycle after the 4th word. cipherkey[0:127] = 000102…0f and [128:255] = 0. keylength128 = 1. key_loaded rises on the cycle after busy_exp falls.
- Plaintext issue:
  - Stimulus: after the 128-bit load, write 00112233, 44556677, 8899aabb, ccddeeff; busy_enc model held 12 cycles.
  - Required: one plaintext_dv pulse with plaintext = 00112233…ccddeeff. wr_ready stays low until busy_enc falls.
  - Checked against `aes_enc`, ciphertext = 69c4e0d86a7b0430d8cdb78070b4c55a.
- Key lengths 192 and 256:
  - Stimulus: key_len = 01 with 6 words, then key_len = 10 with 8 words; flip key_len on word 2.
  - Required: dv fires after word 6 and word 8 respectively. The correct single keylength* bit is set. The key_len flip is ignored.
- Rejections:
  - Stimulus: plaintext write before any key; key_len = 11 on a first key word.
  - Required: wr_err pulses 1 cycle each; pt_cnt and key_cnt stay 0; no dv pulse.
- Simultaneous completion:
  - Stimulus: with a key loaded, fill 4 plaintext words, then complete a new key in the same idle window with busy_exp = 0.
  - Required: cipherkey_dv precedes plaintext_dv, separated by ≥ GUARD_CYC+1 cycles.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle in KEY_WAIT and separately after 3 key words.
  - Required: all outputs return to reset values; no dv pulse follows; the next 4-word key loads normally.
